lif_param_serializer: RTL and testbench

LIF_PARAM_SERIALIZER -- requirements
Module: lif_param_serializer

---
 rtl/lif_param_serializer.sv | 135 +++++++++++++
 tb/tb_lif_param_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lif_param_serializer.sv
// lif_param_serializer
//   Serialises one 48-bit LIF neuron parameter frame to the parameter loader.
//   A frame is one PREAMBLE cycle, then 48 data cycles (MSB first), both with
//   load_enable_out high. It ends with GAP_CYCLES cycles with load_enable_out
//   low, which return the loader to IDLE. After the gap the block re-enters
//   IDLE and pulses done. Every output is registered and changes on the same
//   edge as the state it belongs to.
//
// Parameters
//   GAP_CYCLES      enable-qualified low cycles after a frame (1..15)
// Ports
//   clk             system clock, rising edge
//   reset           synchronous, active-high; overrides enable and start
//   enable          clock-enable for state, counters and outputs
//   start           request one frame (ignored while busy)
//   weight_a        [2:0] weight A
//   leak_rate_1/2   [7:0] leak rates
//   threshold       [7:0] firing threshold
//   leak_cycles_1/2 [3:0] leak periods
//   serial_data_out serial data, MSB first
//   load_enable_out frame-valid strobe to the loader
//   busy            high whenever the state is not IDLE
//   done            one-clk pulse when the frame completes
module lif_param_serializer #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    input  logic [2:0] weight_a,
    input  logic [7:0] leak_rate_1,
    input  logic [7:0] leak_rate_2,
    input  logic [7:0] threshold,
    input  logic [3:0] leak_cycles_1,
    input  logic [3:0] leak_cycles_2,
    output logic       serial_data_out,
    output logic       load_enable_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        SHIFT    = 2'd2,
        GAP      = 2'd3
    } state_t;

    localparam logic [5:0] LAST_BIT = 6'd47;
    localparam logic [3:0] LAST_GAP = 4'(GAP_CYCLES - 1);

    state_t      state;
    logic [5:0]  bit_count;
    logic [3:0]  gap_count;
    logic [47:0] shift_reg;
    logic [47:0] frame;

    always_comb begin
        frame = {5'b0, weight_a, leak_rate_1, leak_rate_2, threshold,
                 4'b0, leak_cycles_1, 4'b0, leak_cycles_2};
    end

    // The shift register is consumed from its MSB, so the bit presented in
    // SHIFT with counter value n is frame bit 47-n.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bit_count       <= '0;
            gap_count       <= '0;
            shift_reg       <= '0;
            serial_data_out <= 1'b0;
            load_enable_out <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            if (enable) begin
                case (state)
                    IDLE: begin
                        serial_data_out <= 1'b0;
                        if (start) begin
                            shift_reg       <= frame;
                            state           <= PREAMBLE;
                            load_enable_out <= 1'b1;
                            busy            <= 1'b1;
                        end else begin
                            load_enable_out <= 1'b0;
                            busy            <= 1'b0;
                        end
                    end
                    PREAMBLE: begin
                        state           <= SHIFT;
                        bit_count       <= '0;
                        load_enable_out <= 1'b1;
                        serial_data_out <= shift_reg[47];
                        shift_reg       <= {shift_reg[46:0], 1'b0};
                    end
                    SHIFT: begin
                        if (bit_count == LAST_BIT) begin
                            state           <= GAP;
                            gap_count       <= '0;
                            load_enable_out <= 1'b0;
                            serial_data_out <= 1'b0;
                        end else begin
                            bit_count       <= bit_count + 6'd1;
                            load_enable_out <= 1'b1;
                            serial_data_out <= shift_reg[47];
                            shift_reg       <= {shift_reg[46:0], 1'b0};
                        end
                    end
                    GAP: begin
                        load_enable_out <= 1'b0;
                        serial_data_out <= 1'b0;
                        if (gap_count == LAST_GAP) begin
                            state     <= IDLE;
                            gap_count <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            gap_count <= gap_count + 4'd1;
                        end
                    end
                    default: begin
                        state           <= IDLE;
                        load_enable_out <= 1'b0;
                        serial_data_out <= 1'b0;
                        busy            <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lif_param_serializer.sv
// Directed testbench for lif_param_serializer (GAP_CYCLES = 2).
// Outputs are sampled 1 time unit after each rising edge, and inputs are
// driven at the same point. run_frame walks one frame edge by edge and
// looks only at enable-qualified edges. On the other edges it requires the
// outputs to stay unchanged and done to be low.
module tb_lif_param_serializer;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       reset, enable, start;
    logic [2:0] weight_a;
    logic [7:0] leak_rate_1, leak_rate_2, threshold;
    logic [3:0] leak_cycles_1, leak_cycles_2;
    logic       serial_data_out, load_enable_out, busy, done;

    int checks = 0;
    int failures = 0;

    // results of the last run_frame call
    logic [47:0] r_bits;
    int r_high, r_low, r_done, r_wait, r_bad;
    bit r_timeout;
    logic [47:0] first_bits;

    lif_param_serializer #(.GAP_CYCLES(GAP)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .start           (start),
        .weight_a        (weight_a),
        .leak_rate_1     (leak_rate_1),
        .leak_rate_2     (leak_rate_2),
        .threshold       (threshold),
        .leak_cycles_1   (leak_cycles_1),
        .leak_cycles_2   (leak_cycles_2),
        .serial_data_out (serial_data_out),
        .load_enable_out (load_enable_out),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_params(input logic [2:0] w, input logic [7:0] l1, input logic [7:0] l2,
                              input logic [7:0] t, input logic [3:0] c1, input logic [3:0] c2);
        weight_a = w; leak_rate_1 = l1; leak_rate_2 = l2;
        threshold = t; leak_cycles_1 = c1; leak_cycles_2 = c2;
    endtask

    // Follows one frame from the accept edge to the done edge.
    // r_high counts the load_enable_out-high cycles (preamble + 48 bits).
    // r_low counts the low gap cycles before the done edge.
    // r_wait counts the enabled edges before load_enable_out rose.
    // poke_at asserts start and clears threshold while data bit poke_at is presented.
    // abort_at raises reset while data bit abort_at is presented, then returns.
    task automatic run_frame(input bit toggle_en, input bit hold_start,
                             input int poke_at, input int abort_at);
        bit   en_cur;
        logic prev_le, prev_sd;
        r_bits = '0; r_high = 0; r_low = 0; r_done = 0; r_wait = 0; r_bad = 0;
        r_timeout = 1'b1;
        prev_le = load_enable_out;
        prev_sd = serial_data_out;
        for (int c = 0; c < 400; c++) begin
            en_cur = enable;
            step();
            if (toggle_en) enable = ~enable;
            if (!en_cur) begin
                if (load_enable_out !== prev_le || serial_data_out !== prev_sd || done !== 1'b0)
                    r_bad++;
                continue;
            end
            prev_le = load_enable_out;
            prev_sd = serial_data_out;
            if (!hold_start && r_high == 0) start = 1'b0;
            if (done === 1'b1) r_done++;
            if (load_enable_out === 1'b1) begin
                if (r_high == 0) begin
                    if (serial_data_out !== 1'b0) r_bad++;
                end else begin
                    r_bits = {r_bits[46:0], serial_data_out};
                end
                if (busy !== 1'b1 || r_low != 0) r_bad++;
                r_high++;
                if (poke_at >= 0 && r_high == poke_at + 2) begin
                    start = 1'b1;
                    threshold = 8'h00;
                end
                if (poke_at >= 0 && r_high == poke_at + 5) start = 1'b0;
                if (abort_at >= 0 && r_high == abort_at + 2) begin
                    reset = 1'b1;
                    r_timeout = 1'b0;
                    return;
                end
            end else if (r_high == 0) begin
                r_wait++;
            end else if (done === 1'b1) begin
                if (busy !== 1'b0 || serial_data_out !== 1'b0) r_bad++;
                r_timeout = 1'b0;
                return;
            end else begin
                if (busy !== 1'b1 || serial_data_out !== 1'b0) r_bad++;
                r_low++;
            end
        end
    endtask

    // Counts the cycles, out of n, in which the block shows any activity.
    task automatic idle_cycles(input int n, output int active);
        active = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (load_enable_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) active++;
        end
    endtask

    task automatic check_frame(input string tag, input logic [47:0] exp_bits);
        check({tag, "_timeout"}, 64'(r_timeout), 64'd0);
        check({tag, "_bits"},    64'(r_bits),    64'(exp_bits));
        check({tag, "_high"},    64'(r_high),    64'd49);
        check({tag, "_gap"},     64'(r_low),     64'(GAP));
        check({tag, "_done"},    64'(r_done),    64'd1);
        check({tag, "_bad"},     64'(r_bad),     64'd0);
    endtask

    initial begin
        int active;

        // Reset wins over a high start, and applies with enable low.
        reset = 1'b1; enable = 1'b0; start = 1'b1;
        set_params(3'd0, 8'd0, 8'd0, 8'd0, 4'd0, 4'd0);
        repeat (3) step();
        check("rst_le",   64'(load_enable_out), 64'd0);
        check("rst_sd",   64'(serial_data_out), 64'd0);
        check("rst_busy", 64'(busy),            64'd0);
        check("rst_done", 64'(done),            64'd0);
        enable = 1'b1;
        step();
        check("rst_start_le", 64'(load_enable_out), 64'd0);
        reset = 1'b0; start = 1'b0;
        idle_cycles(3, active);
        check("idle_quiet", 64'(active), 64'd0);

        // Default frame.
        set_params(3'd2, 8'd2, 8'd1, 8'd30, 4'd2, 4'd4);
        start = 1'b1;
        run_frame(1'b0, 1'b0, -1, -1);
        check_frame("default", 48'b00000010_00000010_00000001_00011110_00000010_00000100);
        check("default_wait", 64'(r_wait), 64'd0);

        // Loopback through a loader model: decode the fields, then require
        // the full gap before params_ready.
        set_params(3'd7, 8'hA5, 8'h3C, 8'hFF, 4'hF, 4'h1);
        start = 1'b1;
        run_frame(1'b0, 1'b0, -1, -1);
        check_frame("loop", 48'h07A53CFF0F01);
        check("loop_weight_a", 64'(r_bits[42:40]), 64'h7);
        check("loop_leak1",    64'(r_bits[39:32]), 64'hA5);
        check("loop_leak2",    64'(r_bits[31:24]), 64'h3C);
        check("loop_thresh",   64'(r_bits[23:16]), 64'hFF);
        check("loop_cyc1",     64'(r_bits[11:8]),  64'hF);
        check("loop_cyc2",     64'(r_bits[3:0]),   64'h1);
        check("loop_params_ready", 64'((r_low == GAP) && !r_timeout), 64'd1);

        // Enable toggles every cycle throughout the frame.
        set_params(3'd5, 8'h81, 8'h7E, 8'h55, 4'hA, 4'h3);
        start = 1'b1;
        run_frame(1'b1, 1'b0, -1, -1);
        check_frame("toggle", 48'h05817E550A03);
        enable = 1'b1;
        step();
        check("toggle_done_clear", 64'(done), 64'd0);

        // start and a threshold change while busy: one frame, captured value.
        set_params(3'd2, 8'd2, 8'd1, 8'h99, 4'd2, 4'd4);
        start = 1'b1;
        run_frame(1'b0, 1'b0, 20, -1);
        check_frame("busy_ign", 48'h020201990204);
        idle_cycles(10, active);
        check("busy_ign_single", 64'(active), 64'd0);

        // Reset while bit 30 is presented.
        set_params(3'd2, 8'd2, 8'd1, 8'd30, 4'd2, 4'd4);
        start = 1'b1;
        run_frame(1'b0, 1'b0, -1, 30);
        check("abort_reached", 64'(r_timeout), 64'd0);
        step();
        check("abort_le",   64'(load_enable_out), 64'd0);
        check("abort_busy", 64'(busy),            64'd0);
        check("abort_done", 64'(done),            64'd0);
        reset = 1'b0;
        idle_cycles(3, active);
        check("abort_quiet", 64'(active), 64'd0);
        start = 1'b1;
        run_frame(1'b0, 1'b0, -1, -1);
        check_frame("after_abort", 48'b00000010_00000010_00000001_00011110_00000010_00000100);

        // Back-to-back with start held high. The second frame rises on the
        // first enabled edge after done, so between frames load_enable_out
        // is low for the GAP cycles plus the done cycle.
        set_params(3'd1, 8'h10, 8'h20, 8'h30, 4'h4, 4'h5);
        start = 1'b1;
        run_frame(1'b0, 1'b1, -1, -1);
        first_bits = r_bits;
        check_frame("b2b_1", 48'h011020300405);
        set_params(3'd6, 8'hC3, 8'h00, 8'h01, 4'h8, 4'h7);
        run_frame(1'b0, 1'b1, -1, -1);
        start = 1'b0;
        check_frame("b2b_2", 48'h06C300010807);
        check("b2b_2_wait", 64'(r_wait), 64'd0);
        check("b2b_distinct", 64'(first_bits != r_bits), 64'd1);
        idle_cycles(5, active);
        check("b2b_stop", 64'(active), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
